// File: rtl/nmea_gga_parser_pkg.sv
// rtl/nmea_gga_parser_pkg.sv - shared FSM encoding, ASCII constants and GGA header table
package nmea_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TIME,
        LAT,
        LAT_HEM,
        LAT_SEP,
        LON,
        LON_HEM
    } state_t;

    localparam logic [7:0] CH_DOLLAR = "$";
    localparam logic [7:0] CH_COMMA  = ",";
    localparam logic [7:0] CH_DOT    = ".";
    localparam logic [7:0] CH_N      = "N";
    localparam logic [7:0] CH_S      = "S";
    localparam logic [7:0] CH_E      = "E";
    localparam logic [7:0] CH_W      = "W";
    localparam logic [7:0] CH_0      = "0";
    localparam logic [7:0] CH_9      = "9";

    localparam logic [39:0] GGA_HDR  = "GPGGA";
    localparam logic [2:0]  HDR_LAST = 3'd5;
    localparam int          CNT_W    = 4;

    // Index 0..4 walks "GPGGA"; the trailing comma closes the header.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        int k;
        k = 4 - int'(idx);
        if (idx >= HDR_LAST) return CH_COMMA;
        return GGA_HDR[8*k +: 8];
    endfunction

endpackage

// File: rtl/nmea_gga_parser_if.sv
// rtl/nmea_gga_parser_if.sv - received UART byte stream into the parser
interface nmea_gga_parser_if;
    logic [7:0] uart_data;
    logic       uart_valid;

    modport master (output uart_data, output uart_valid);
    modport slave  (input  uart_data, input  uart_valid);
endinterface

// File: rtl/nmea_gga_parser_bcd_field.sv
// rtl/nmea_gga_parser_bcd_field.sv - per-field BCD digit shifter, digit counter and fraction flag
module nmea_bcd_field
    import nmea_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  digit_en,
    input  logic                  dot_en,
    input  logic [3:0]            digit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [CNT_W-1:0]      cnt,
    output logic                  frac
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd  <= '0;
            cnt  <= '0;
            frac <= 1'b0;
        end else if (clr) begin
            bcd  <= '0;
            cnt  <= '0;
            frac <= 1'b0;
        end else if (dot_en) begin
            frac <= 1'b1;
        end else if (digit_en && !frac && (cnt < CNT_W'(DIGITS))) begin
            bcd <= {bcd[4*DIGITS-5:0], digit};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nmea_gga_parser.sv
// rtl/nmea_gga_parser.sv - $GPGGA time/lat/lon extractor; NMEA_ERR_CNT_EN adds a saturating err_cnt
module nmea_gga_parser
    import nmea_pkg::*;
#(
    parameter int TIME_DIGITS = 6,
    parameter int LAT_DIGITS  = 4,
    parameter int LON_DIGITS  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    nmea_gga_parser_if.slave          uart,
    output logic [4*TIME_DIGITS-1:0]  utc_bcd,
    output logic [4*LAT_DIGITS-1:0]   lat_bcd,
    output logic                      lat_south,
    output logic [4*LON_DIGITS-1:0]   lon_bcd,
    output logic                      lon_west,
    output logic                      fix_valid,
    output logic                      parse_err
`ifdef NMEA_ERR_CNT_EN
    ,output logic [7:0]               err_cnt
`endif
);

    state_t      state;
    logic [2:0]  hdr_idx;
    logic        lat_s_pend;

    logic [7:0]  b;
    logic        v, is_digit, clr, over;
    logic [CNT_W-1:0] t_cnt, la_cnt, lo_cnt, cur_cnt, cur_need;
    logic        t_frac, la_frac, lo_frac, cur_frac;
    logic [4*TIME_DIGITS-1:0] t_bcd;
    logic [4*LAT_DIGITS-1:0]  la_bcd;
    logic [4*LON_DIGITS-1:0]  lo_bcd;

    assign b        = uart.uart_data;
    assign v        = uart.uart_valid;
    assign is_digit = (b >= CH_0) && (b <= CH_9);
    assign clr      = v && (b == CH_DOLLAR);

    nmea_bcd_field #(.DIGITS(TIME_DIGITS)) u_time (
        .clk(clk), .rst(rst), .clr(clr),
        .digit_en(v && state == TIME && is_digit), .dot_en(v && state == TIME && b == CH_DOT),
        .digit(b[3:0]), .bcd(t_bcd), .cnt(t_cnt), .frac(t_frac));

    nmea_bcd_field #(.DIGITS(LAT_DIGITS)) u_lat (
        .clk(clk), .rst(rst), .clr(clr),
        .digit_en(v && state == LAT && is_digit), .dot_en(v && state == LAT && b == CH_DOT),
        .digit(b[3:0]), .bcd(la_bcd), .cnt(la_cnt), .frac(la_frac));

    nmea_bcd_field #(.DIGITS(LON_DIGITS)) u_lon (
        .clk(clk), .rst(rst), .clr(clr),
        .digit_en(v && state == LON && is_digit), .dot_en(v && state == LON && b == CH_DOT),
        .digit(b[3:0]), .bcd(lo_bcd), .cnt(lo_cnt), .frac(lo_frac));

    always_comb begin
        cur_cnt  = '0;
        cur_need = '0;
        cur_frac = 1'b0;
        case (state)
            TIME: begin cur_cnt = t_cnt;  cur_need = CNT_W'(TIME_DIGITS); cur_frac = t_frac;  end
            LAT:  begin cur_cnt = la_cnt; cur_need = CNT_W'(LAT_DIGITS);  cur_frac = la_frac; end
            LON:  begin cur_cnt = lo_cnt; cur_need = CNT_W'(LON_DIGITS);  cur_frac = lo_frac; end
            default: ;
        endcase
    end

    // An integer digit arriving when the field is already full aborts the sentence.
    assign over = is_digit && !cur_frac && (cur_cnt == cur_need);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            lat_s_pend <= 1'b0;
            utc_bcd    <= '0;
            lat_bcd    <= '0;
            lat_south  <= 1'b0;
            lon_bcd    <= '0;
            lon_west   <= 1'b0;
            fix_valid  <= 1'b0;
            parse_err  <= 1'b0;
        end else begin
            fix_valid <= 1'b0;
            parse_err <= 1'b0;
            if (v) begin
                if (b == CH_DOLLAR) begin
                    state   <= HDR;
                    hdr_idx <= '0;
                    if (state != IDLE) parse_err <= 1'b1;
                end else begin
                    case (state)
                        IDLE: ;
                        HDR: begin
                            if (b != hdr_byte(hdr_idx)) begin
                                parse_err <= 1'b1;
                                state     <= IDLE;
                            end else if (hdr_idx == HDR_LAST) begin
                                state <= TIME;
                            end else begin
                                hdr_idx <= hdr_idx + 1'b1;
                            end
                        end
                        TIME, LAT, LON: begin
                            if (is_digit) begin
                                if (over) begin
                                    parse_err <= 1'b1;
                                    state     <= IDLE;
                                end
                            end else if (b == CH_COMMA) begin
                                if (cur_cnt != cur_need) begin
                                    parse_err <= 1'b1;
                                    state     <= IDLE;
                                end else if (state == TIME) begin
                                    state <= LAT;
                                end else if (state == LAT) begin
                                    state <= LAT_HEM;
                                end else begin
                                    state <= LON_HEM;
                                end
                            end else if (b != CH_DOT) begin
                                parse_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        LAT_HEM: begin
                            if (b == CH_N || b == CH_S) begin
                                lat_s_pend <= (b == CH_S);
                                state      <= LAT_SEP;
                            end else begin
                                parse_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        LAT_SEP: begin
                            if (b == CH_COMMA) begin
                                state <= LON;
                            end else begin
                                parse_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        LON_HEM: begin
                            if (b == CH_E || b == CH_W) begin
                                utc_bcd   <= t_bcd;
                                lat_bcd   <= la_bcd;
                                lat_south <= lat_s_pend;
                                lon_bcd   <= lo_bcd;
                                lon_west  <= (b == CH_W);
                                fix_valid <= 1'b1;
                            end else begin
                                parse_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef NMEA_ERR_CNT_EN
    // Counts the registered pulse, so err_cnt trails parse_err by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (parse_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
